// File: rtl/cpu_exec_controller_if.sv
// ---------------------------------------------------------------------------
// cpu_exec_controller_if
// Bundles the board-facing signals of the execution controller.
//   btn_run / btn_step          : raw asynchronous push buttons (run/pause, step)
//   btn_view_next/btn_view_prev : raw asynchronous push buttons (display scroll)
//   pc                          : current CPU program counter
//   bp_en / bp_pc               : breakpoint switch and breakpoint address
//   clk_en                      : CPU state-update enable
//   state                       : 00 IDLE, 01 RUN, 10 STEP, 11 DONE
//   done / bp_hit               : program-finished level, breakpoint-stop pulse
//   retired                     : saturating count of enabled CPU cycles
//   view_addr                   : data-memory word shown on the display
// The controller attaches through "master"; the board/CPU side through "slave".
// ---------------------------------------------------------------------------
interface cpu_exec_controller_if #(
    parameter int PC_W    = 32,
    parameter int VIEW_AW = 3,
    parameter int CNT_W   = 16
);
    logic               btn_run;
    logic               btn_step;
    logic               btn_view_next;
    logic               btn_view_prev;
    logic [PC_W-1:0]    pc;
    logic               bp_en;
    logic [PC_W-1:0]    bp_pc;
    logic               clk_en;
    logic [1:0]         state;
    logic               done;
    logic               bp_hit;
    logic [CNT_W-1:0]   retired;
    logic [VIEW_AW-1:0] view_addr;

    modport master (
        input  btn_run, btn_step, btn_view_next, btn_view_prev, pc, bp_en, bp_pc,
        output clk_en, state, done, bp_hit, retired, view_addr
    );

    modport slave (
        output btn_run, btn_step, btn_view_next, btn_view_prev, pc, bp_en, bp_pc,
        input  clk_en, state, done, bp_hit, retired, view_addr
    );
endinterface

// File: rtl/cpu_exec_controller.sv
// ---------------------------------------------------------------------------
// cpu_exec_controller
// Run / single-step / breakpoint execution controller for the single-cycle
// MIPS core. Produces the CPU clock-enable, a saturating retired-instruction
// counter and a wrapping data-memory display address.
// Ports:
//   clk   : board clock
//   reset : synchronous active-high reset
//   bus   : cpu_exec_controller_if.master (buttons, pc, breakpoint in;
//           clk_en, state, done, bp_hit, retired, view_addr out)
// ---------------------------------------------------------------------------
module cpu_exec_controller #(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] DONE_PC     = PC_W'(32'h0000_0040),
    parameter int              VIEW_DEPTH  = 8,
    parameter int              VIEW_AW     = 3,
    parameter int              CNT_W       = 16,
    parameter int              SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_exec_controller_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam int                 NBTN      = 4;
    localparam logic [VIEW_AW-1:0] VIEW_LAST = VIEW_AW'(VIEW_DEPTH - 1);
    localparam logic [VIEW_AW-1:0] VIEW_ONE  = VIEW_AW'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    // Button bit order: 0 run, 1 step, 2 view next, 3 view prev.
    logic [NBTN-1:0]                  btn_s;
    logic [NBTN-1:0]                  pulse_s;
    logic [SYNC_STAGES-1:0][NBTN-1:0] sync_q;
    logic [NBTN-1:0]                  last_q;

    logic               run_p_s, step_p_s, next_p_s, prev_p_s;
    logic               at_done_s, bp_stop_s;
    state_t             state_q, state_d;
    logic               first_run_q, first_run_d;
    logic               bp_hit_q, bp_hit_d;
    logic               done_q;
    logic               clk_en_s;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [VIEW_AW-1:0] view_q, view_d;

    assign btn_s    = {bus.btn_view_prev, bus.btn_view_next, bus.btn_step, bus.btn_run};
    // Rising edge of the synchronised level: newest settled sample high, previous low.
    assign pulse_s  = sync_q[SYNC_STAGES-1] & ~last_q;
    assign run_p_s  = pulse_s[0];
    assign step_p_s = pulse_s[1];
    assign next_p_s = pulse_s[2];
    assign prev_p_s = pulse_s[3];

    assign at_done_s = (bus.pc == DONE_PC);
    // The first RUN cycle after a resume must execute the instruction it stopped on.
    assign bp_stop_s = bus.bp_en && (bus.pc == bus.bp_pc) && !first_run_q;

    // Button synchroniser chains and edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {(SYNC_STAGES*NBTN){1'b0}};
            last_q <= {NBTN{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_s};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // FSM state register plus registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            first_run_q <= 1'b0;
            bp_hit_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_run_q <= first_run_d;
            bp_hit_q    <= bp_hit_d;
            done_q      <= (state_d == ST_DONE);
        end
    end

    // FSM next-state logic; stop conditions in RUN are checked by priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (at_done_s)     state_d = ST_DONE;
                else if (run_p_s)  state_d = ST_RUN;
                else if (step_p_s) state_d = ST_STEP;
                else               state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (at_done_s)      state_d = ST_DONE;
                else if (bp_stop_s) state_d = ST_IDLE;
                else if (run_p_s)   state_d = ST_IDLE;
                else                state_d = ST_RUN;
            end
            ST_STEP: begin
                if (at_done_s) state_d = ST_DONE;
                else           state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: CPU enable, breakpoint pulse request and first-run marker.
    always_comb begin
        clk_en_s    = 1'b0;
        bp_hit_d    = 1'b0;
        first_run_d = 1'b0;
        if (reset) begin
            clk_en_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: first_run_d = !at_done_s && run_p_s;
                ST_RUN: begin
                    clk_en_s = !(at_done_s || bp_stop_s || run_p_s);
                    bp_hit_d = !at_done_s && bp_stop_s;
                end
                ST_STEP: clk_en_s = !at_done_s;
                ST_DONE: clk_en_s = 1'b0;
                default: clk_en_s = 1'b0;
            endcase
        end
    end

    // Retired counter next value, saturating at all-ones.
    always_comb begin
        if (clk_en_s && (retired_q != CNT_MAX)) retired_d = retired_q + CNT_ONE;
        else                                    retired_d = retired_q;
    end

    // View address next value; simultaneous next/prev cancel out.
    always_comb begin
        view_d = view_q;
        if (next_p_s && !prev_p_s) begin
            if (view_q >= VIEW_LAST) view_d = {VIEW_AW{1'b0}};
            else                     view_d = view_q + VIEW_ONE;
        end else if (prev_p_s && !next_p_s) begin
            if (view_q == {VIEW_AW{1'b0}}) view_d = VIEW_LAST;
            else                           view_d = view_q - VIEW_ONE;
        end else begin
            view_d = view_q;
        end
    end

    // Counter and view address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= {CNT_W{1'b0}};
            view_q    <= {VIEW_AW{1'b0}};
        end else begin
            retired_q <= retired_d;
            view_q    <= view_d;
        end
    end

    assign bus.clk_en    = clk_en_s;
    assign bus.state     = state_q;
    assign bus.done      = done_q;
    assign bus.bp_hit    = bp_hit_q;
    assign bus.retired   = retired_q;
    assign bus.view_addr = view_q;

endmodule

// File: tb/tb_cpu_exec_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_exec_controller
// Self-checking bench for cpu_exec_controller. A simple CPU model advances
// the PC by 4 on every enabled cycle; scenario tasks drive the buttons and
// compare against expectations derived from instruction counts and modular
// view arithmetic. A second instance with VIEW_DEPTH=5 checks view wrapping.
// ---------------------------------------------------------------------------
module tb_cpu_exec_controller;
    localparam int          S       = 2;
    localparam logic [31:0] DONE_PC = 32'h0000_0040;
    localparam logic [1:0]  IDLE    = 2'b00;
    localparam logic [1:0]  RUN     = 2'b01;
    localparam logic [1:0]  STEP    = 2'b10;
    localparam logic [1:0]  DONE    = 2'b11;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m8 = 0;
    int   m5 = 0;

    always #5 clk = ~clk;

    cpu_exec_controller_if #(.PC_W(32), .VIEW_AW(3), .CNT_W(16)) bus8 ();
    cpu_exec_controller_if #(.PC_W(32), .VIEW_AW(3), .CNT_W(16)) bus5 ();

    cpu_exec_controller #(.PC_W(32), .DONE_PC(DONE_PC), .VIEW_DEPTH(8), .VIEW_AW(3),
                          .CNT_W(16), .SYNC_STAGES(S))
        dut8 (.clk(clk), .reset(reset), .bus(bus8));

    cpu_exec_controller #(.PC_W(32), .DONE_PC(DONE_PC), .VIEW_DEPTH(5), .VIEW_AW(3),
                          .CNT_W(16), .SYNC_STAGES(S))
        dut5 (.clk(clk), .reset(reset), .bus(bus5));

    // CPU model: the PC advances one instruction per enabled cycle.
    logic [31:0] pc_m;
    always @(posedge clk) begin
        if (reset)            pc_m <= 32'd0;
        else if (bus8.clk_en) pc_m <= pc_m + 32'd4;
    end
    assign bus8.pc = pc_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus8.btn_run = 1'b0; bus8.btn_step = 1'b0;
        bus8.btn_view_next = 1'b0; bus8.btn_view_prev = 1'b0;
        bus5.btn_view_next = 1'b0; bus5.btn_view_prev = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m8 = 0;
        m5 = 0;
    endtask

    // One-cycle press; returns just after the edge on which it takes effect.
    task automatic press_run();
        bus8.btn_run = 1'b1;
        tick();
        bus8.btn_run = 1'b0;
        repeat (S) tick();
    endtask

    task automatic wait_leave_run(input int limit);
        for (int i = 0; i < limit && bus8.state == RUN; i++) tick();
    endtask

    task automatic view_op(input bit nx, input bit pv);
        bus8.btn_view_next = nx; bus8.btn_view_prev = pv;
        bus5.btn_view_next = nx; bus5.btn_view_prev = pv;
        tick();
        bus8.btn_view_next = 1'b0; bus8.btn_view_prev = 1'b0;
        bus5.btn_view_next = 1'b0; bus5.btn_view_prev = 1'b0;
        repeat (S + 1) tick();
        if (nx && !pv) begin
            m8 = (m8 + 1) % 8;
            m5 = (m5 + 1) % 5;
        end else if (pv && !nx) begin
            m8 = (m8 + 7) % 8;
            m5 = (m5 + 4) % 5;
        end
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        tick();
        n_tests++; if (bus8.state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", bus8.state, IDLE); end
        n_tests++; if (bus8.clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en got %0b want 0", bus8.clk_en); end
        n_tests++; if (bus8.done !== 1'b0 || bus8.bp_hit !== 1'b0) begin n_fail++; $display("FAIL reset_flags got done=%0b bp_hit=%0b want 0/0", bus8.done, bus8.bp_hit); end
        n_tests++; if (bus8.retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", bus8.retired); end
        n_tests++; if (bus8.view_addr !== 3'd0 || bus5.view_addr !== 3'd0) begin n_fail++; $display("FAIL reset_view got %0d/%0d want 0/0", bus8.view_addr, bus5.view_addr); end
        reset = 1'b0;
    endtask

    task automatic test_run_to_done();
        int hold;
        int en_cnt;
        do_reset();
        bus8.bp_en = 1'b0;
        hold = int'($urandom_range(1, S));
        bus8.btn_run = 1'b1;
        for (int i = 1; i <= S; i++) begin
            tick();
            if (i == hold) bus8.btn_run = 1'b0;
        end
        n_tests++; if (bus8.state !== IDLE) begin n_fail++; $display("FAIL run_latency_early got %0d want %0d", bus8.state, IDLE); end
        tick();
        bus8.btn_run = 1'b0;
        n_tests++; if (bus8.state !== RUN || bus8.clk_en !== 1'b1) begin n_fail++; $display("FAIL run_latency got state=%0d clk_en=%0b want 1/1", bus8.state, bus8.clk_en); end
        en_cnt = 0;
        for (int i = 0; i < 100 && bus8.state != DONE; i++) begin
            if (bus8.clk_en) en_cnt++;
            tick();
        end
        n_tests++; if (bus8.state !== DONE || bus8.done !== 1'b1) begin n_fail++; $display("FAIL run_done got state=%0d done=%0b want 3/1", bus8.state, bus8.done); end
        n_tests++; if (pc_m !== DONE_PC || bus8.clk_en !== 1'b0) begin n_fail++; $display("FAIL run_done_pc got pc=%0h clk_en=%0b want 40/0", pc_m, bus8.clk_en); end
        n_tests++; if (bus8.retired !== 16'd16 || en_cnt != 16) begin n_fail++; $display("FAIL run_retired got %0d (enables %0d) want 16", bus8.retired, en_cnt); end
    endtask

    task automatic test_step();
        int en_cnt;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            en_cnt = 0;
            bus8.btn_step = 1'b1;
            tick();
            bus8.btn_step = 1'b0;
            if (bus8.clk_en) en_cnt++;
            for (int i = 0; i < 9; i++) begin
                tick();
                if (bus8.clk_en) en_cnt++;
            end
            n_tests++; if (en_cnt != 1) begin n_fail++; $display("FAIL step_pulse%0d got %0d enable cycles want 1", p, en_cnt); end
            n_tests++; if (bus8.state !== IDLE) begin n_fail++; $display("FAIL step_idle%0d got %0d want %0d", p, bus8.state, IDLE); end
            repeat ($urandom_range(0, 4)) tick();
        end
        n_tests++; if (bus8.retired !== 16'd3 || pc_m !== 32'h0000_000C) begin n_fail++; $display("FAIL step_retired got %0d pc=%0h want 3 pc=c", bus8.retired, pc_m); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        bus8.bp_en = 1'b1;
        bus8.bp_pc = 32'h0000_0020;
        press_run();
        wait_leave_run(100);
        n_tests++; if (bus8.state !== IDLE || bus8.bp_hit !== 1'b1) begin n_fail++; $display("FAIL bp_stop got state=%0d bp_hit=%0b want 0/1", bus8.state, bus8.bp_hit); end
        n_tests++; if (pc_m !== 32'h0000_0020 || bus8.retired !== 16'd8) begin n_fail++; $display("FAIL bp_pc got pc=%0h retired=%0d want 20/8", pc_m, bus8.retired); end
        tick();
        n_tests++; if (bus8.bp_hit !== 1'b0 || pc_m !== 32'h0000_0020) begin n_fail++; $display("FAIL bp_pulse_len got bp_hit=%0b pc=%0h want 0/20", bus8.bp_hit, pc_m); end
        press_run();
        n_tests++; if (bus8.state !== RUN || bus8.clk_en !== 1'b1) begin n_fail++; $display("FAIL bp_resume got state=%0d clk_en=%0b want 1/1", bus8.state, bus8.clk_en); end
        wait_leave_run(100);
        n_tests++; if (bus8.state !== DONE || bus8.retired !== 16'd16) begin n_fail++; $display("FAIL bp_done got state=%0d retired=%0d want 3/16", bus8.state, bus8.retired); end
        bus8.bp_en = 1'b0;
    endtask

    task automatic test_pause();
        do_reset();
        press_run();
        for (int i = 0; i < 100 && pc_m != (32'h0000_0010 - 32'(4 * S)); i++) tick();
        bus8.btn_run = 1'b1;
        tick();
        bus8.btn_run = 1'b0;
        repeat (S - 1) tick();
        n_tests++; if (pc_m !== 32'h0000_0010 || bus8.clk_en !== 1'b0) begin n_fail++; $display("FAIL pause_cycle got pc=%0h clk_en=%0b want 10/0", pc_m, bus8.clk_en); end
        repeat ($urandom_range(1, 6)) tick();
        n_tests++; if (bus8.state !== IDLE || pc_m !== 32'h0000_0010 || bus8.retired !== 16'd4) begin n_fail++; $display("FAIL pause_hold got state=%0d pc=%0h retired=%0d want 0/10/4", bus8.state, pc_m, bus8.retired); end
        press_run();
        wait_leave_run(100);
        n_tests++; if (bus8.state !== DONE || pc_m !== DONE_PC) begin n_fail++; $display("FAIL pause_resume got state=%0d pc=%0h want 3/40", bus8.state, pc_m); end
        press_run();
        press_run();
        bus8.btn_step = 1'b1;
        tick();
        bus8.btn_step = 1'b0;
        repeat (S + 1) tick();
        n_tests++; if (bus8.state !== DONE || bus8.done !== 1'b1 || bus8.clk_en !== 1'b0 || bus8.retired !== 16'd16) begin n_fail++; $display("FAIL done_absorb got state=%0d done=%0b clk_en=%0b retired=%0d want 3/1/0/16", bus8.state, bus8.done, bus8.clk_en, bus8.retired); end
    endtask

    task automatic test_view();
        int op;
        do_reset();
        repeat (9) view_op(1'b1, 1'b0);
        n_tests++; if (bus8.view_addr !== 3'd1 || bus5.view_addr !== 3'd4) begin n_fail++; $display("FAIL view_next9 got %0d/%0d want 1/4", bus8.view_addr, bus5.view_addr); end
        do_reset();
        repeat (2) view_op(1'b0, 1'b1);
        n_tests++; if (bus8.view_addr !== 3'd6 || bus5.view_addr !== 3'd3) begin n_fail++; $display("FAIL view_prev2 got %0d/%0d want 6/3", bus8.view_addr, bus5.view_addr); end
        view_op(1'b1, 1'b1);
        n_tests++; if (bus8.view_addr !== 3'd6 || bus5.view_addr !== 3'd3) begin n_fail++; $display("FAIL view_both got %0d/%0d want 6/3", bus8.view_addr, bus5.view_addr); end
        m8 = 6;
        m5 = 3;
        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 3));
            view_op(op[0], op[1]);
            n_tests++; if (int'(bus8.view_addr) != m8 || int'(bus5.view_addr) != m5) begin n_fail++; $display("FAIL view_rand%0d got %0d/%0d want %0d/%0d", i, bus8.view_addr, bus5.view_addr, m8, m5); end
        end
    endtask

    task automatic test_reset_mid_run();
        int    entries;
        logic [1:0] prev;
        do_reset();
        view_op(1'b1, 1'b0);
        press_run();
        for (int i = 0; i < 100 && pc_m != 32'h0000_0018; i++) tick();
        n_tests++; if (bus8.state !== RUN || pc_m !== 32'h0000_0018 || bus8.view_addr !== 3'd1) begin n_fail++; $display("FAIL midrun_setup got state=%0d pc=%0h view=%0d want 1/18/1", bus8.state, pc_m, bus8.view_addr); end
        reset = 1'b1;
        bus8.btn_run = 1'b1;
        #1;
        n_tests++; if (bus8.clk_en !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_clk_en got %0b want 0", bus8.clk_en); end
        tick();
        n_tests++; if (bus8.state !== IDLE || bus8.clk_en !== 1'b0 || bus8.retired !== 16'd0 || bus8.view_addr !== 3'd0) begin n_fail++; $display("FAIL midrun_reset got state=%0d clk_en=%0b retired=%0d view=%0d want 0/0/0/0", bus8.state, bus8.clk_en, bus8.retired, bus8.view_addr); end
        tick();
        reset = 1'b0;
        entries = 0;
        prev = bus8.state;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (prev != RUN && bus8.state == RUN) entries++;
            prev = bus8.state;
        end
        n_tests++; if (entries != 1 || bus8.state !== DONE || bus8.retired !== 16'd16) begin n_fail++; $display("FAIL held_run got entries=%0d state=%0d retired=%0d want 1/3/16", entries, bus8.state, bus8.retired); end
        bus8.btn_run = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus8.btn_run = 1'b0; bus8.btn_step = 1'b0;
        bus8.btn_view_next = 1'b0; bus8.btn_view_prev = 1'b0;
        bus8.bp_en = 1'b0; bus8.bp_pc = 32'd0;
        bus5.btn_run = 1'b0; bus5.btn_step = 1'b0;
        bus5.btn_view_next = 1'b0; bus5.btn_view_prev = 1'b0;
        bus5.bp_en = 1'b0; bus5.bp_pc = 32'd0; bus5.pc = 32'd0;
        test_reset();
        test_run_to_done();
        test_step();
        test_breakpoint();
        test_pause();
        test_view();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
